// File: rtl/i2s_tx_serializer_pkg.sv
// Shared I2S definitions: lane geometry, word-length encodings and the TX master state set.
package I2sGlobalPkg;

    localparam int DATA_WIDTH    = 8;
    localparam int MAXIMUM_SIZE  = 4;
    localparam int MAX_WORD_BITS = DATA_WIDTH * MAXIMUM_SIZE;

    typedef enum logic [1:0] {
        BITS_8  = 2'b00,
        BITS_16 = 2'b01,
        BITS_24 = 2'b10,
        BITS_32 = 2'b11
    } numOfBitsTransferEnum;

    localparam logic [1:0] CFG_BITS_8  = BITS_8;
    localparam logic [1:0] CFG_BITS_16 = BITS_16;
    localparam logic [1:0] CFG_BITS_24 = BITS_24;
    localparam logic [1:0] CFG_BITS_32 = BITS_32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } i2sTxStateEnum;

    // Word length in bits for a cfg_bits code, in units of byte lanes.
    function automatic int unsigned word_bits(input logic [1:0] cfg, input int unsigned lane_w);
        int unsigned n;
        case (cfg)
            CFG_BITS_8:  n = lane_w;
            CFG_BITS_16: n = 2 * lane_w;
            CFG_BITS_24: n = 3 * lane_w;
            default:     n = 4 * lane_w;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/i2s_sclk_gen.sv
// Serial clock divider: toggles sclk every CLK_DIV clk while run is high, and
// always completes a high phase before parking low.
module i2s_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic sclk,
    output logic rise_stb,
    output logic fall_stb
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    logic             sclk_q, sclk_d;
    logic             active;
    logic             tick;

    always_comb begin
        active = run || sclk_q;
        tick   = active && (div_q == DIV_W'(CLK_DIV - 1));
        div_d  = div_q;
        sclk_d = sclk_q;
        if (!active) begin
            div_d = '0;
        end else if (tick) begin
            div_d  = '0;
            sclk_d = !sclk_q;
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            sclk_q <= sclk_d;
        end
    end

    // Strobes flag the clk in which sclk is about to change, so registers
    // updated on fall_stb switch together with the falling edge.
    assign rise_stb = tick && !sclk_q;
    assign fall_stb = tick && sclk_q;
    assign sclk     = sclk_q;

endmodule

// File: rtl/i2s_tx_serializer.sv
// I2S TX master: 1-deep pair holding register, frame FSM and MSB-first shifter.
// Optional underrun_cnt output when I2S_TX_UNDERRUN_CNT_EN is defined.
module i2s_tx_serializer #(
    parameter int DATA_WIDTH   = I2sGlobalPkg::DATA_WIDTH,
    parameter int MAXIMUM_SIZE = I2sGlobalPkg::MAXIMUM_SIZE,
    parameter int CLK_DIV      = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               tx_enable,
    input  logic [1:0]                         cfg_bits,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [DATA_WIDTH*MAXIMUM_SIZE-1:0] in_left,
    input  logic [DATA_WIDTH*MAXIMUM_SIZE-1:0] in_right,
    output logic                               sclk,
    output logic                               ws,
    output logic                               sd,
    output logic                               busy,
    output logic                               underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    output logic [15:0]                        underrun_cnt
`endif
);

    import I2sGlobalPkg::*;

    localparam int WORD_W = DATA_WIDTH * MAXIMUM_SIZE;
    localparam int CNT_W  = $clog2(2 * WORD_W) + 1;

    i2sTxStateEnum     state_q, state_d;
    logic              hold_full_q, hold_full_d;
    logic [WORD_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
    logic              in_ready_q, in_ready_d;
    logic [WORD_W-1:0] sh_l_q, sh_l_d, sh_r_q, sh_r_d;
    logic [CNT_W-1:0]  k_q, k_d, n_q, n_d;
    logic              loaded_q, loaded_d;
    logic              ws_q, ws_d, sd_q, sd_d;
    logic              underrun_q, underrun_d;

    logic              sclk_run, sclk_w, rise_stb, fall_stb;
    logic              in_run, accept, boundary, do_stop, do_load, from_hold, zero_fill, advance;
    logic [CNT_W-1:0]  two_n, n_new, k_nxt, k_wrap;
    logic [WORD_W-1:0] word_l, word_r, algn_l, algn_r;

    i2s_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk      (clk),
        .rst      (rst),
        .run      (sclk_run),
        .sclk     (sclk_w),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
    );

    // Frame boundary: the first fall in RUN, or the fall ending bit 2N-1.
    always_comb begin
        in_run    = (state_q == RUN);
        accept    = in_valid && in_ready_q;
        two_n     = n_q << 1;
        boundary  = in_run && fall_stb && (!loaded_q || (k_q == two_n - 1'b1));
        do_stop   = boundary && loaded_q && !tx_enable;
        do_load   = boundary && !do_stop;
        from_hold = do_load && hold_full_q;
        zero_fill = do_load && !hold_full_q;
        advance   = in_run && fall_stb && !boundary;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (tx_enable && hold_full_q) state_d = RUN;
            RUN:     if (do_stop) state_d = STOP;
            STOP:    if (!sclk_w && !rise_stb) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q != IDLE);
        sclk_run = (state_q == RUN);
    end

    // Holding register; a pair accepted alongside a load waits for the next frame.
    always_comb begin
        hold_full_d = hold_full_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        if (from_hold) begin
            hold_full_d = 1'b0;
        end
        if (accept) begin
            hold_full_d = 1'b1;
            hold_l_d    = in_left;
            hold_r_d    = in_right;
        end
        in_ready_d = !hold_full_d;
    end

    always_comb begin
        sh_l_d     = sh_l_q;
        sh_r_d     = sh_r_q;
        k_d        = k_q;
        n_d        = n_q;
        loaded_d   = loaded_q;
        ws_d       = ws_q;
        sd_d       = sd_q;
        underrun_d = underrun_q || zero_fill;
        n_new      = CNT_W'(word_bits(cfg_bits, DATA_WIDTH));
        word_l     = from_hold ? hold_l_q : '0;
        word_r     = from_hold ? hold_r_q : '0;
        algn_l     = word_l << (CNT_W'(WORD_W) - n_new);
        algn_r     = word_r << (CNT_W'(WORD_W) - n_new);
        k_nxt      = k_q + 1'b1;
        k_wrap     = ((k_nxt + 1'b1) == two_n) ? '0 : (k_nxt + 1'b1);
        if (do_load) begin
            n_d      = n_new;
            k_d      = '0;
            loaded_d = 1'b1;
            sd_d     = algn_l[WORD_W-1];
            sh_l_d   = algn_l << 1;
            sh_r_d   = algn_r;
            ws_d     = (CNT_W'(1) >= n_new);
        end else if (advance) begin
            k_d  = k_nxt;
            // ws looks one bit ahead so it flips one sclk before each MSB.
            ws_d = (k_wrap >= n_q);
            if (k_nxt < n_q) begin
                sd_d   = sh_l_q[WORD_W-1];
                sh_l_d = sh_l_q << 1;
            end else begin
                sd_d   = sh_r_q[WORD_W-1];
                sh_r_d = sh_r_q << 1;
            end
        end else if (do_stop) begin
            loaded_d = 1'b0;
            ws_d     = 1'b0;
            sd_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_full_q <= 1'b0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            in_ready_q  <= 1'b0;
            sh_l_q      <= '0;
            sh_r_q      <= '0;
            k_q         <= '0;
            n_q         <= '0;
            loaded_q    <= 1'b0;
            ws_q        <= 1'b0;
            sd_q        <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            hold_full_q <= hold_full_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            in_ready_q  <= in_ready_d;
            sh_l_q      <= sh_l_d;
            sh_r_q      <= sh_r_d;
            k_q         <= k_d;
            n_q         <= n_d;
            loaded_q    <= loaded_d;
            ws_q        <= ws_d;
            sd_q        <= sd_d;
            underrun_q  <= underrun_d;
        end
    end

`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [15:0] ucnt_q, ucnt_d;

    always_comb begin
        ucnt_d = ucnt_q;
        if (zero_fill && (ucnt_q != 16'hFFFF)) begin
            ucnt_d = ucnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ucnt_q <= '0;
        end else begin
            ucnt_q <= ucnt_d;
        end
    end

    assign underrun_cnt = ucnt_q;
`endif

    assign in_ready = in_ready_q;
    assign sclk     = sclk_w;
    assign ws       = ws_q;
    assign sd       = sd_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Bench for i2s_tx_serializer: a receiver-style monitor captures {ws,sd} on every
// sclk rise and compares against bit streams built from the I2S framing rules.
module tb_i2s_tx_serializer;

    localparam int CLK_DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tx_enable = 1'b0;
    logic [1:0]  cfg_bits = 2'b00;
    logic        in_valid = 1'b0;
    logic [31:0] in_left = '0;
    logic [31:0] in_right = '0;
    logic        in_ready, sclk, ws, sd, busy, underrun;
`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [1:0] cap_q[$];
    logic [1:0] exp_q[$];
    int   cyc = 0;
    int   last_rise = -1;
    int   gap_min = 1000000;
    int   gap_max = 0;
    logic sclk_prev = 1'b0;

    always #5 clk = ~clk;

    i2s_tx_serializer #(.CLK_DIV(CLK_DIV)) dut (
        .clk          (clk),
        .rst          (rst),
        .tx_enable    (tx_enable),
        .cfg_bits     (cfg_bits),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_left      (in_left),
        .in_right     (in_right),
        .sclk         (sclk),
        .ws           (ws),
        .sd           (sd),
        .busy         (busy),
        .underrun     (underrun)
`ifdef I2S_TX_UNDERRUN_CNT_EN
        ,
        .underrun_cnt (underrun_cnt)
`endif
    );

    // Receiver view: sample ws/sd at each sclk rising edge.
    always @(negedge clk) begin
        cyc++;
        if (!rst && sclk && !sclk_prev) begin
            cap_q.push_back({ws, sd});
            if (last_rise >= 0) begin
                if (cyc - last_rise < gap_min) gap_min = cyc - last_rise;
                if (cyc - last_rise > gap_max) gap_max = cyc - last_rise;
            end
            last_rise = cyc;
        end
        sclk_prev = sclk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic int nbits_of(input logic [1:0] c);
        return 8 * (int'(c) + 1);
    endfunction

    // Expected receiver samples for one frame of n-bit words.
    task automatic model_frame(input logic [31:0] l, input logic [31:0] r, input int n);
        logic bit_v, ws_v;
        for (int k = 0; k < 2 * n; k++) begin
            bit_v = (k < n) ? l[n - 1 - k] : r[2 * n - 1 - k];
            ws_v  = (((k + 1) % (2 * n)) >= n);
            exp_q.push_back({ws_v, bit_v});
        end
    endtask

    task automatic clear_capture();
        cap_q.delete();
        exp_q.delete();
        last_rise = -1;
        gap_min   = 1000000;
        gap_max   = 0;
        exp_q.push_back(2'b00);  // preamble rise before the first load
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; tx_enable = 1'b0; in_valid = 1'b0;
        repeat (3) @(negedge clk);
        clear_capture();
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_pair(input logic [31:0] l, input logic [31:0] r);
        bit ok = 1'b0;
        in_left = l; in_right = r; in_valid = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            if (in_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (ok) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL send_pair timeout in_ready=%b need 1", in_ready); end
    endtask

    task automatic wait_cap(input int n);
        for (int i = 0; i < 20000 && cap_q.size() < n; i++) @(negedge clk);
        checks++;
        if (cap_q.size() < n) begin
            errors++; $display("FAIL wait_cap timeout got %0d rises need %0d", cap_q.size(), n);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20000 && busy; i++) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL wait_idle timeout busy=%b need 0", busy); end
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 20000 && !in_ready; i++) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL wait_ready timeout in_ready=%b need 1", in_ready); end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({sclk, ws, sd, busy, underrun, in_ready} !== 6'b0) begin
            errors++; $display("FAIL reset_outs got %b need 000000", {sclk, ws, sd, busy, underrun, in_ready});
        end
`ifdef I2S_TX_UNDERRUN_CNT_EN
        checks++;
        if (underrun_cnt !== 16'd0) begin errors++; $display("FAIL reset_ucnt got %0d need 0", underrun_cnt); end
`endif
        clear_capture();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b need 1", in_ready); end
        // Enable without a pair must not start.
        tx_enable = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if ({busy, sclk} !== 2'b00) begin errors++; $display("FAIL idle_nostart got %b need 00", {busy, sclk}); end
        tx_enable = 1'b0;
    endtask

    task automatic test_basic();
        int bad;
        apply_reset();
        cfg_bits = 2'b00;
        send_pair(32'h0000_00A5, 32'h0000_003C);
        model_frame(32'hA5, 32'h3C, 8);
        tx_enable = 1'b1;
        wait_cap(2);
        tx_enable = 1'b0;
        wait_idle();
        checks++;
        if (cap_q.size() !== exp_q.size()) begin errors++; $display("FAIL basic_len got %0d need %0d", cap_q.size(), exp_q.size()); end
        bad = -1;
        foreach (exp_q[i]) if (bad < 0 && i < cap_q.size() && cap_q[i] !== exp_q[i]) bad = i;
        checks++;
        if (bad >= 0) begin errors++; $display("FAIL basic_bits idx %0d got %b need %b", bad, cap_q[bad], exp_q[bad]); end
        checks++;
        if (gap_min !== 2 * CLK_DIV || gap_max !== 2 * CLK_DIV) begin
            errors++; $display("FAIL basic_period got %0d..%0d need %0d", gap_min, gap_max, 2 * CLK_DIV);
        end
        checks++;
        if ({sclk, ws, sd, underrun} !== 4'b0) begin errors++; $display("FAIL basic_park got %b need 0000", {sclk, ws, sd, underrun}); end
    endtask

    task automatic test_back_to_back();
        int bad;
        logic [31:0] l2, r2;
        apply_reset();
        cfg_bits = 2'b11;
        l2 = $urandom(); r2 = $urandom();
        send_pair(32'hDEADBEEF, 32'h12345678);
        tx_enable = 1'b1;
        send_pair(32'hCAFEF00D, 32'h0BADC0DE);
        send_pair(l2, r2);
        model_frame(32'hDEADBEEF, 32'h12345678, 32);
        model_frame(32'hCAFEF00D, 32'h0BADC0DE, 32);
        model_frame(l2, r2, 32);
        wait_ready();
        tx_enable = 1'b0;
        wait_idle();
        checks++;
        if (cap_q.size() !== exp_q.size()) begin errors++; $display("FAIL b2b_len got %0d need %0d", cap_q.size(), exp_q.size()); end
        bad = -1;
        foreach (exp_q[i]) if (bad < 0 && i < cap_q.size() && cap_q[i] !== exp_q[i]) bad = i;
        checks++;
        if (bad >= 0) begin errors++; $display("FAIL b2b_bits idx %0d got %b need %b", bad, cap_q[bad], exp_q[bad]); end
        checks++;
        if (gap_min !== 2 * CLK_DIV || gap_max !== 2 * CLK_DIV) begin
            errors++; $display("FAIL b2b_gap got %0d..%0d need %0d", gap_min, gap_max, 2 * CLK_DIV);
        end
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL b2b_underrun got %b need 0", underrun); end
    endtask

    task automatic test_underrun();
        int bad, n;
        logic [31:0] l, r;
        apply_reset();
        cfg_bits = 2'($urandom_range(0, 3));
        n = nbits_of(cfg_bits);
        l = $urandom(); r = $urandom();
        send_pair(l, r);
        model_frame(l, r, n);
        model_frame(32'h0, 32'h0, n);
        tx_enable = 1'b1;
        wait_cap(1 + 2 * n);
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL urun_early got %b need 0", underrun); end
        wait_cap(2 + 2 * n);
        tx_enable = 1'b0;
        wait_idle();
        checks++;
        if (cap_q.size() !== exp_q.size()) begin errors++; $display("FAIL urun_len got %0d need %0d", cap_q.size(), exp_q.size()); end
        bad = -1;
        foreach (exp_q[i]) if (bad < 0 && i < cap_q.size() && cap_q[i] !== exp_q[i]) bad = i;
        checks++;
        if (bad >= 0) begin errors++; $display("FAIL urun_bits idx %0d got %b need %b", bad, cap_q[bad], exp_q[bad]); end
        checks++;
        if (underrun !== 1'b1) begin errors++; $display("FAIL urun_flag got %b need 1", underrun); end
`ifdef I2S_TX_UNDERRUN_CNT_EN
        checks++;
        if (underrun_cnt !== 16'd1) begin errors++; $display("FAIL urun_cnt got %0d need 1", underrun_cnt); end
`endif
    endtask

    task automatic test_stop_mid();
        int bad;
        logic [31:0] l, r;
        apply_reset();
        cfg_bits = 2'b01;
        l = $urandom(); r = $urandom();
        send_pair(l, r);
        model_frame(l, r, 16);
        tx_enable = 1'b1;
        wait_cap(1 + 4);  // bit k=3 on the wire
        tx_enable = 1'b0;
        wait_idle();
        checks++;
        if (cap_q.size() !== exp_q.size()) begin errors++; $display("FAIL stop_len got %0d need %0d", cap_q.size(), exp_q.size()); end
        bad = -1;
        foreach (exp_q[i]) if (bad < 0 && i < cap_q.size() && cap_q[i] !== exp_q[i]) bad = i;
        checks++;
        if (bad >= 0) begin errors++; $display("FAIL stop_bits idx %0d got %b need %b", bad, cap_q[bad], exp_q[bad]); end
        repeat (20) @(negedge clk);
        checks++;
        if ({sclk, ws, busy} !== 3'b0) begin errors++; $display("FAIL stop_park got %b need 000", {sclk, ws, busy}); end
    endtask

    task automatic test_reset_mid();
        int bad, n;
        logic [31:0] l, r;
        apply_reset();
        cfg_bits = 2'($urandom_range(0, 3));
        n = nbits_of(cfg_bits);
        l = $urandom(); r = $urandom();
        send_pair(l, r);
        tx_enable = 1'b1;
        wait_cap(1 + 6);  // bit k=5 on the wire, sclk high
        checks++;
        if ({busy, sclk} !== 2'b11) begin errors++; $display("FAIL rstmid_pre got %b need 11", {busy, sclk}); end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({sclk, ws, sd, busy, in_ready} !== 5'b0) begin
            errors++; $display("FAIL rstmid_async got %b need 00000", {sclk, ws, sd, busy, in_ready});
        end
        tx_enable = 1'b0;
        repeat (3) @(negedge clk);
        clear_capture();
        rst = 1'b0;
        @(negedge clk);
        l = $urandom(); r = $urandom();
        send_pair(l, r);
        model_frame(l, r, n);
        tx_enable = 1'b1;
        wait_cap(2);
        tx_enable = 1'b0;
        wait_idle();
        checks++;
        if (cap_q.size() !== exp_q.size()) begin errors++; $display("FAIL rstmid_len got %0d need %0d", cap_q.size(), exp_q.size()); end
        bad = -1;
        foreach (exp_q[i]) if (bad < 0 && i < cap_q.size() && cap_q[i] !== exp_q[i]) bad = i;
        checks++;
        if (bad >= 0) begin errors++; $display("FAIL rstmid_bits idx %0d got %b need %b", bad, cap_q[bad], exp_q[bad]); end
    endtask

    task automatic test_cfg_change();
        int bad;
        logic [31:0] l1, r1, l2, r2;
        apply_reset();
        cfg_bits = 2'b01;
        l1 = $urandom(); r1 = $urandom(); l2 = $urandom(); r2 = $urandom();
        send_pair(l1, r1);
        tx_enable = 1'b1;
        send_pair(l2, r2);
        model_frame(l1, r1, 16);
        model_frame(l2, r2, 24);
        wait_cap(1 + 5);
        cfg_bits = 2'b10;
        wait_cap(1 + 32 + 1);
        tx_enable = 1'b0;
        wait_idle();
        checks++;
        if (cap_q.size() !== exp_q.size()) begin errors++; $display("FAIL cfg_len got %0d need %0d", cap_q.size(), exp_q.size()); end
        bad = -1;
        foreach (exp_q[i]) if (bad < 0 && i < cap_q.size() && cap_q[i] !== exp_q[i]) bad = i;
        checks++;
        if (bad >= 0) begin errors++; $display("FAIL cfg_bits idx %0d got %b need %b", bad, cap_q[bad], exp_q[bad]); end
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL cfg_underrun got %b need 0", underrun); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_underrun();
        test_stop_mid();
        test_reset_mid();
        test_cfg_change();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
